serial_divide: RTL



---
 rtl/serial_divide_pkg.sv | 22 ++
 rtl/serial_divide_core.sv | 69 ++++++
 rtl/serial_divide.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_divide_pkg.sv
// Shared types and helpers for the serial restoring divider.
package serial_divide_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIX,
    DONE
  } state_e;

  // Operands are sign-extended to this width before magnitude extraction.
  localparam int ABS_W = 64;

  function automatic int cnt_width(input int width_n);
    return $clog2(width_n + 1);
  endfunction

  function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] x);
    return x[ABS_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/serial_divide_core.sv
// Unsigned restoring shift/subtract datapath: one quotient bit per step.
module serial_div_core
  import serial_divide_pkg::*;
#(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_N-1:0] remainder,
  output logic               last
);

  localparam int CNT_W = cnt_width(WIDTH_N);

  logic [WIDTH_N-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH_D-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_N:0]   partial, trial;

  always_comb begin
    partial = {rem_q, quo_q[WIDTH_N-1]};
    trial   = partial - (WIDTH_N+1)'(dvs_q);
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    if (load) begin
      // The dividend shifts out of quo_q's top while quotient bits enter below.
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (!trial[WIDTH_N]) begin
        rem_d = trial[WIDTH_N-1:0];
        quo_d = {quo_q[WIDTH_N-2:0], 1'b1};
      end else begin
        rem_d = partial[WIDTH_N-1:0];
        quo_d = {quo_q[WIDTH_N-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CNT_W'(WIDTH_N - 1));

endmodule

// File: rtl/serial_divide.sv
// Iterative divider with start/running/done handshake; signed results truncate toward zero.
module serial_divide
  import serial_divide_pkg::*;
#(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 4,
  parameter bit SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               running,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_N-1:0] remainder,
  output logic               div_by_zero
);

  state_e             state_q, state_d;
  logic               running_q, running_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH_N-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic               neg_dvd_q, neg_dvd_d, neg_dvs_q, neg_dvs_d, dvz_q, dvz_d;
  logic               load, step, last, neg_dvd, neg_dvs;
  logic [WIDTH_N-1:0] core_quo, core_rem, dvd_mag;
  logic [WIDTH_D-1:0] dvs_mag;
  logic [ABS_W-1:0]   dvd_ext, dvs_ext;

  always_comb begin
    neg_dvd = SIGNED && dividend[WIDTH_N-1];
    neg_dvs = SIGNED && divisor[WIDTH_D-1];
    dvd_ext = {{(ABS_W-WIDTH_N){neg_dvd}}, dividend};
    dvs_ext = {{(ABS_W-WIDTH_D){neg_dvs}}, divisor};
    dvd_mag = WIDTH_N'(abs_val(dvd_ext));
    dvs_mag = WIDTH_D'(abs_val(dvs_ext));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DONE also accepts a start, giving one operation per WIDTH_N+2 clocks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DIVIDE;
      DIVIDE:  if (last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? DIVIDE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load        = start && (state_q == IDLE || state_q == DONE);
    step        = (state_q == DIVIDE);
    running_d   = (state_d == DIVIDE) || (state_d == FIX);
    done_d      = (state_d == DONE);
    neg_dvd_d   = load ? neg_dvd : neg_dvd_q;
    neg_dvs_d   = load ? neg_dvs : neg_dvs_q;
    dvz_d       = load ? (divisor == '0) : dvz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = load ? 1'b0 : dbz_q;
    if (state_q == FIX) begin
      // A zero divisor always reports all ones, whatever the dividend sign.
      quotient_d  = dvz_q ? '1 : ((neg_dvd_q ^ neg_dvs_q) ? -core_quo : core_quo);
      remainder_d = neg_dvd_q ? -core_rem : core_rem;
      dbz_d       = dvz_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      neg_dvd_q   <= 1'b0;
      neg_dvs_q   <= 1'b0;
      dvz_q       <= 1'b0;
    end else begin
      running_q   <= running_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      neg_dvd_q   <= neg_dvd_d;
      neg_dvs_q   <= neg_dvs_d;
      dvz_q       <= dvz_d;
    end
  end

  serial_div_core #(
    .WIDTH_N(WIDTH_N),
    .WIDTH_D(WIDTH_D)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quotient (core_quo),
    .remainder(core_rem),
    .last     (last)
  );

  assign running     = running_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
